gptp_tx_framer: RTL and testbench
=================================

Name: gptp_tx_framer

Overview:
- MAC-side consumer of the gPTP egress interface of gptp_top.
- Accepts one 352-bit gPTP frame per handshake and serialises it as a byte stream toward the PHY/link.
- Captures the local RTC at start-of-frame, the instant the first byte is accepted. Adds a fixed egress latency to that capture and returns the 80-bit egress timestamp on gptp_ts_rv_*.
- Closes the loop that gptp_top needs for Sync/Pdelay t1/t3 measurement.

Parameters:
- FRAME_BYTES, 44: bytes per frame; equals gptp_ts_data width / 8.
- EGRESS_LATENCY_NS, 0: constant added to the captured nanoseconds. Legal range 0..999_999_999.

Ports:
- clk  in  1  block clock, the same domain as the local rtc.
- reset  in  1  asynchronous, active-low reset.
- gptp_ts_vaild  in  1  frame offered by gptp_top.
- gptp_ts_ready  out  1  block can accept a frame.
- gptp_ts_data  in  352  frame; byte 0 = bits [351:344].
- rtc_nanosec_field  in  32  local RTC ns, always < 1e9.
- rtc_sec_field  in  32  local RTC seconds.
- rtc_epoch_field  in  16  local RTC epoch.
- gptp_ts_rv_vaild  out  1  one-cycle egress-timestamp strobe.
- gptp_ts_rv_data  out  80  {epoch[79:64], sec[63:32], ns[31:0]}.
- tx_data  out  8  serial byte.
- tx_vaild  out  1  tx_data valid.
- tx_last  out  1  final byte of the frame.
- tx_ready  in  1  downstream accepts the byte.

Behaviour:
- Reset (reset=0, async): state IDLE, byte counter 0.
  - gptp_ts_ready=0 while reset is asserted, 1 from the first clock after release.
  - tx_vaild=0, tx_last=0, tx_data=0.
  - gptp_ts_rv_vaild=0, gptp_ts_rv_data=0.
  - Any frame in flight is discarded; no timestamp is produced for it.
- FSM states: IDLE -> SEND -> DONE -> IDLE.
- IDLE:
  - gptp_ts_ready=1.
  - On gptp_ts_vaild&&gptp_ts_ready, latch gptp_ts_data, clear the counter and go to SEND.
  - tx_vaild rises the next cycle.
- SEND:
  - gptp_ts_ready=0; tx_vaild=1; tx_data=frame[351-8*cnt -: 8].
  - tx_last=1 iff cnt==FRAME_BYTES-1.
  - The counter advances only on tx_vaild&&tx_ready. tx_data and tx_last hold stable while tx_ready=0.
  - SOF capture: on the cycle the byte-0 handshake occurs, register {rtc_epoch,rtc_sec,rtc_ns} as sampled in that cycle. A stall before byte 0 therefore moves the timestamp.
  - On the handshake of the last byte, go to DONE.
- DONE (exactly one cycle):
  - gptp_ts_rv_vaild=1 with the adjusted timestamp; tx_vaild=0; then go to IDLE.
  - gptp_ts_rv_data holds its value until the next DONE.
- Timestamp adjustment, with raw capture (E,S,N) and L=EGRESS_LATENCY_NS:
  - t=N+L, 31-bit unsigned, no overflow.
  - If t>=1_000_000_000: ns=t-1e9 and carry=1.
  - S+carry wraps 0xFFFFFFFF->0 and increments E. E wraps 0xFFFF->0.
  - Computed during SEND; ready on DONE entry (frame length >= 1 cycle).
- Latency:
  - Accept to first tx_vaild: 1 cycle.
  - Last byte handshake to gptp_ts_rv_vaild: 1 cycle.
  - With tx_ready held at 1, accept to next gptp_ts_ready=1 is FRAME_BYTES+2 cycles.
- gptp_ts_vaild is ignored outside IDLE; the source must hold the frame, as gptp_top already does.

Decomposition:
- Package gptp_pkg holds:
  - NS_PER_SEC = 1_000_000_000.
  - GPTP_FRAME_W = 352, GPTP_TS_W = 80.
  - State encoding for IDLE/SEND/DONE.
  - A timestamp struct with epoch16/sec32/ns32 fields.
- One combinational sub-module, gptp_ts_add: timestamp plus an unsigned ns constant with sec/epoch carry. It is reusable by the ingress side.

Test Plan:
- Single frame, tx_ready=1, byte k = k (0x00..0x2B) -> 44 bytes in order; tx_last only on 0x2B; gptp_ts_rv_vaild one cycle, one clock after the last byte; gptp_ts_ready returns 46 cycles after accept.
- L=20, RTC at SOF = epoch 1, sec 5, ns 999_999_990 -> gptp_ts_rv_data = {16'd1, 32'd6, 32'd10}.
- L=1, RTC = epoch 0x0003, sec 0xFFFFFFFF, ns 999_999_999 -> {16'd4, 32'd0, 32'd0}.
- tx_ready=0 for 10 cycles before byte 0 while the RTC advances 8 ns/cycle -> timestamp ns = RTC at the handshake cycle (accept-cycle value + 80 + L). Random tx_ready during the body -> byte stream intact, tx_data stable while stalled.
- gptp_ts_vaild held high continuously -> gptp_ts_ready=0 throughout SEND/DONE; the second frame is accepted the cycle after DONE; two complete frames and two timestamp strobes.
- reset asserted at byte 20 for 2 cycles -> all outputs 0 immediately, no timestamp strobe; after release gptp_ts_ready=1 and the next frame starts from byte 0.

Source files
------------

// File: rtl/gptp_pkg.sv
// gptp_pkg: shared constants, FSM state encoding and the timestamp type
// for the gPTP framing blocks.
//   NS_PER_SEC   - nanoseconds per second, the ns-field rollover point
//   GPTP_FRAME_W - width of one gPTP frame on the egress interface
//   GPTP_TS_W    - width of a packed {epoch, sec, ns} timestamp
//   tx_state_e   - TX framer states IDLE / SEND / DONE
//   gptp_ts_t    - packed timestamp, epoch in the top bits, ns in the bottom
package gptp_pkg;

  localparam logic [31:0] NS_PER_SEC   = 32'd1_000_000_000;
  localparam int          GPTP_FRAME_W = 352;
  localparam int          GPTP_TS_W    = 80;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic [15:0] epoch;
    logic [31:0] sec;
    logic [31:0] ns;
  } gptp_ts_t;

endpackage

// File: rtl/gptp_ts_add.sv
// gptp_ts_add: combinational timestamp adder. Adds a constant number of
// nanoseconds to a timestamp, folding ns overflow into the seconds field
// and seconds overflow into the epoch field. Usable on ingress and egress.
//   ADD_NS  - nanoseconds to add, 0..999_999_999
//   ts_in   - timestamp with ns < 1e9
//   ts_out  - ts_in + ADD_NS, normalised (ns < 1e9, sec/epoch wrap)
module gptp_ts_add
  import gptp_pkg::*;
#(
  parameter int unsigned ADD_NS = 0
) (
  input  gptp_ts_t ts_in,
  output gptp_ts_t ts_out
);

  localparam logic [31:0] ADD = 32'(ADD_NS);

  logic [31:0] ns_sum;
  logic        carry;
  logic [32:0] sec_sum;

  // Both operands are below 1e9, so the sum stays below 2e9 and needs at
  // most one subtraction of NS_PER_SEC to normalise.
  always_comb begin
    ns_sum       = ts_in.ns + ADD;
    carry        = (ns_sum >= NS_PER_SEC);
    sec_sum      = {1'b0, ts_in.sec} + {32'd0, carry};
    ts_out.ns    = carry ? (ns_sum - NS_PER_SEC) : ns_sum;
    ts_out.sec   = sec_sum[31:0];
    ts_out.epoch = ts_in.epoch + {15'd0, sec_sum[32]};
  end

endmodule

// File: rtl/gptp_tx_framer.sv
// gptp_tx_framer: MAC-side consumer of the gPTP egress interface. Accepts
// one frame per handshake, serialises it MSB-byte first, captures the local
// RTC on the byte-0 handshake and returns that capture plus a fixed egress
// latency as a one-cycle timestamp strobe after the last byte.
//   clk, reset          - clock (RTC domain), async active-low reset
//   gptp_ts_vaild/ready - frame handshake from gptp_top
//   gptp_ts_data        - frame, byte 0 in the top 8 bits
//   rtc_*_field         - live local RTC {epoch, sec, ns}
//   gptp_ts_rv_vaild    - one-cycle egress timestamp strobe
//   gptp_ts_rv_data     - {epoch, sec, ns}, held until the next strobe
//   tx_data/vaild/last  - byte stream toward the link, tx_ready back-pressure
module gptp_tx_framer
  import gptp_pkg::*;
#(
  parameter int          FRAME_BYTES       = 44,
  parameter int unsigned EGRESS_LATENCY_NS = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     gptp_ts_vaild,
  output logic                     gptp_ts_ready,
  input  logic [FRAME_BYTES*8-1:0] gptp_ts_data,
  input  logic [31:0]              rtc_nanosec_field,
  input  logic [31:0]              rtc_sec_field,
  input  logic [15:0]              rtc_epoch_field,
  output logic                     gptp_ts_rv_vaild,
  output logic [GPTP_TS_W-1:0]     gptp_ts_rv_data,
  output logic [7:0]               tx_data,
  output logic                     tx_vaild,
  output logic                     tx_last,
  input  logic                     tx_ready
);

  localparam int FRAME_W = FRAME_BYTES * 8;
  localparam int CNT_W   = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BYTES - 1);

  tx_state_e          state, state_next;
  logic               alive;
  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-1:0] frame_q;
  gptp_ts_t           sof_ts;
  gptp_ts_t           rv_q;
  gptp_ts_t           rtc_now;
  gptp_ts_t           add_in;
  gptp_ts_t           adj_ts;
  logic               accept;
  logic               byte_hs;
  logic               is_last;

  assign rtc_now = {rtc_epoch_field, rtc_sec_field, rtc_nanosec_field};

  // On the byte-0 cycle the capture register is not yet loaded, so the adder
  // looks at the live RTC; this keeps one-byte frames correct.
  assign add_in  = (cnt == '0) ? rtc_now : sof_ts;

  gptp_ts_add #(
    .ADD_NS(EGRESS_LATENCY_NS)
  ) u_ts_add (
    .ts_in (add_in),
    .ts_out(adj_ts)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // gptp_ts_ready is gated by 'alive' so it stays low until the first
  // clock after reset release.
  always_comb begin
    state_next       = state;
    gptp_ts_ready    = 1'b0;
    tx_vaild         = 1'b0;
    tx_last          = 1'b0;
    gptp_ts_rv_vaild = 1'b0;
    accept           = 1'b0;
    byte_hs          = 1'b0;
    is_last          = (cnt == LAST_CNT);
    case (state)
      ST_IDLE: begin
        gptp_ts_ready = alive;
        if (gptp_ts_vaild && alive) begin
          accept     = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_vaild = 1'b1;
        tx_last  = is_last;
        if (tx_ready) begin
          byte_hs = 1'b1;
          if (is_last) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        gptp_ts_rv_vaild = 1'b1;
        state_next       = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The frame is shifted one byte per handshake, so the current byte is
  // always the top byte and holds still while tx_ready is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive   <= 1'b0;
      cnt     <= '0;
      frame_q <= '0;
      sof_ts  <= '0;
      rv_q    <= '0;
    end else begin
      alive <= 1'b1;
      if (accept) begin
        frame_q <= gptp_ts_data;
        cnt     <= '0;
      end else if (byte_hs) begin
        frame_q <= {frame_q[FRAME_W-9:0], 8'h00};
        cnt     <= cnt + CNT_W'(1);
      end
      if (byte_hs && (cnt == '0)) begin
        sof_ts <= rtc_now;
      end
      if (byte_hs && is_last) begin
        rv_q <= adj_ts;
      end
    end
  end

  assign tx_data         = tx_vaild ? frame_q[FRAME_W-1 -: 8] : 8'h00;
  assign gptp_ts_rv_data = rv_q;

endmodule

// File: tb/tb_gptp_tx_framer.sv
// tb_gptp_tx_framer: scoreboard bench for gptp_tx_framer with a 20 ns
// egress latency. Stimulus pushes expected bytes and timestamps into
// queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_gptp_tx_framer;
  import gptp_pkg::*;

  localparam int          NB = 44;
  localparam int unsigned LAT = 20;

  logic          clk;
  logic          reset;
  logic          gptp_ts_vaild;
  logic          gptp_ts_ready;
  logic [351:0]  gptp_ts_data;
  logic [31:0]   rtc_nanosec_field;
  logic [31:0]   rtc_sec_field;
  logic [15:0]   rtc_epoch_field;
  logic          gptp_ts_rv_vaild;
  logic [79:0]   gptp_ts_rv_data;
  logic [7:0]    tx_data;
  logic          tx_vaild;
  logic          tx_last;
  logic          tx_ready;

  logic [31:0]   rtc_ns_base;
  logic          rtc_run;
  int            rtc_ticks;

  logic [8:0]    exp_q[$];
  logic [79:0]   ts_q[$];

  int            n_checks;
  int            n_fail;
  int            cyc;
  int            last_cyc;
  logic          prev_stall;
  logic [7:0]    prev_data;
  logic          prev_last;
  logic          prev_rv;

  gptp_tx_framer #(
    .FRAME_BYTES(NB),
    .EGRESS_LATENCY_NS(LAT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .gptp_ts_vaild    (gptp_ts_vaild),
    .gptp_ts_ready    (gptp_ts_ready),
    .gptp_ts_data     (gptp_ts_data),
    .rtc_nanosec_field(rtc_nanosec_field),
    .rtc_sec_field    (rtc_sec_field),
    .rtc_epoch_field  (rtc_epoch_field),
    .gptp_ts_rv_vaild (gptp_ts_rv_vaild),
    .gptp_ts_rv_data  (gptp_ts_rv_data),
    .tx_data          (tx_data),
    .tx_vaild         (tx_vaild),
    .tx_last          (tx_last),
    .tx_ready         (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The RTC ns field advances 8 ns per clock while rtc_run is set.
  always @(posedge clk) rtc_ticks <= rtc_run ? rtc_ticks + 1 : 0;
  assign rtc_nanosec_field = rtc_ns_base + 32'(rtc_ticks * 8);

  task automatic checkOutput(input string name, input logic [79:0] act,
                             input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] mk_ts(input logic [15:0] e, input logic [31:0] s,
                                        input logic [31:0] n);
    return {e, s, n};
  endfunction

  function automatic logic [351:0] make_frame(input logic [7:0] base, input logic [7:0] step);
    logic [351:0] f;
    logic [7:0]   b;
    f = '0;
    b = base;
    for (int k = 0; k < NB; k++) begin
      f[351-8*k -: 8] = b;
      b = b + step;
    end
    return f;
  endfunction

  task automatic push_expect(input logic [351:0] f, input logic [79:0] ts);
    for (int k = 0; k < NB; k++) begin
      exp_q.push_back({(k == NB-1), f[351-8*k -: 8]});
    end
    ts_q.push_back(ts);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!gptp_ts_ready && n < 200) begin
      tick();
      n++;
    end
    checkOutput("ready_wait", 80'(gptp_ts_ready), 80'(1));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ts_q.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    checkOutput("drain", 80'(exp_q.size() + ts_q.size()), 80'(0));
  endtask

  // Offers a frame with tx_ready held high and returns once it has drained.
  task automatic applyStimulus(input logic [351:0] f, input logic [79:0] ts);
    push_expect(f, ts);
    gptp_ts_data  = f;
    gptp_ts_vaild = 1'b1;
    wait_ready();
    tick();
    gptp_ts_vaild = 1'b0;
    wait_drain();
    wait_ready();
  endtask

  // Monitor: pops and compares on every byte handshake and timestamp strobe.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      prev_stall = 1'b0;
      prev_rv    = 1'b0;
    end else begin
      if (tx_vaild) begin
        checkOutput("ready_low_send", 80'(gptp_ts_ready), 80'(0));
        if (prev_stall) begin
          checkOutput("stall_data", 80'(tx_data), 80'(prev_data));
          checkOutput("stall_last", 80'(tx_last), 80'(prev_last));
        end
        if (tx_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("extra_byte", 80'(tx_data), 80'hDEAD);
          end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            checkOutput("tx_data", 80'(tx_data), 80'(e[7:0]));
            checkOutput("tx_last", 80'(tx_last), 80'(e[8]));
          end
          if (tx_last) last_cyc = cyc;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_data  = tx_data;
          prev_last  = tx_last;
        end
      end else begin
        prev_stall = 1'b0;
      end
      if (gptp_ts_rv_vaild) begin
        checkOutput("ready_low_done", 80'(gptp_ts_ready), 80'(0));
        checkOutput("rv_latency", 80'(cyc - last_cyc), 80'(1));
        checkOutput("rv_one_cycle", 80'(prev_rv), 80'(0));
        if (ts_q.size() == 0) begin
          checkOutput("unexpected_ts", gptp_ts_rv_data, 80'hBAD);
        end else begin
          checkOutput("ts", gptp_ts_rv_data, ts_q.pop_front());
        end
      end
      prev_rv = gptp_ts_rv_vaild;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [351:0] f;
    logic [351:0] f2;
    int           n;
    n_checks          = 0;
    n_fail            = 0;
    cyc               = 0;
    last_cyc          = 0;
    prev_stall        = 1'b0;
    prev_rv           = 1'b0;
    prev_data         = 8'h00;
    prev_last         = 1'b0;
    reset             = 1'b0;
    gptp_ts_vaild     = 1'b0;
    gptp_ts_data      = '0;
    rtc_ns_base       = 32'd0;
    rtc_sec_field     = 32'd0;
    rtc_epoch_field   = 16'd0;
    rtc_run           = 1'b0;
    tx_ready          = 1'b1;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_ready", 80'(gptp_ts_ready), 80'(0));
    checkOutput("rst_tx_vaild", 80'(tx_vaild), 80'(0));
    checkOutput("rst_tx_data", 80'(tx_data), 80'(0));
    checkOutput("rst_rv_data", gptp_ts_rv_data, 80'(0));
    reset = 1'b1;
    #1;
    checkOutput("release_ready_pre", 80'(gptp_ts_ready), 80'(0));
    tick();
    checkOutput("release_ready_post", 80'(gptp_ts_ready), 80'(1));

    // Frame of bytes 0x00..0x2B, ns carry into seconds
    $display("[TB] single frame, latencies");
    rtc_epoch_field = 16'd1;
    rtc_sec_field   = 32'd5;
    rtc_ns_base     = 32'd999_999_990;
    f = make_frame(8'h00, 8'h01);
    push_expect(f, mk_ts(16'd1, 32'd6, 32'd10));
    gptp_ts_data  = f;
    gptp_ts_vaild = 1'b1;
    wait_ready();
    tick();
    gptp_ts_vaild = 1'b0;
    checkOutput("first_tx_latency", 80'(tx_vaild), 80'(1));
    n = 1;
    while (!gptp_ts_ready && n < 100) begin
      tick();
      n++;
    end
    checkOutput("ready_return_cycles", 80'(n), 80'(46));
    wait_drain();

    // Seconds wrap into epoch
    $display("[TB] sec/epoch wrap");
    rtc_epoch_field = 16'h0003;
    rtc_sec_field   = 32'hFFFF_FFFF;
    rtc_ns_base     = 32'd999_999_999;
    applyStimulus(make_frame(8'hA5, 8'h03), mk_ts(16'd4, 32'd0, 32'd19));

    // Stall before byte 0 with running RTC, then random back-pressure
    $display("[TB] stall before SOF, random body");
    rtc_epoch_field = 16'd7;
    rtc_sec_field   = 32'd42;
    f = make_frame(8'h10, 8'h07);
    push_expect(f, mk_ts(16'd7, 32'd42, 32'd1100));
    tx_ready      = 1'b0;
    gptp_ts_data  = f;
    gptp_ts_vaild = 1'b1;
    wait_ready();
    rtc_ns_base = 32'd1000;
    rtc_run     = 1'b1;
    tick();
    gptp_ts_vaild = 1'b0;
    repeat (9) tick();
    tx_ready = 1'b1;
    tick();
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tx_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    tx_ready = 1'b1;
    rtc_run  = 1'b0;
    wait_drain();
    wait_ready();

    // Valid held high: back-to-back frames
    $display("[TB] back-to-back frames");
    rtc_epoch_field = 16'd2;
    rtc_sec_field   = 32'd100;
    rtc_ns_base     = 32'd500;
    f  = make_frame(8'h40, 8'h01);
    f2 = make_frame(8'hC0, 8'h05);
    push_expect(f, mk_ts(16'd2, 32'd100, 32'd520));
    push_expect(f2, mk_ts(16'd2, 32'd100, 32'd520));
    gptp_ts_data  = f;
    gptp_ts_vaild = 1'b1;
    wait_ready();
    tick();
    gptp_ts_data = f2;
    n = 1;
    while (!gptp_ts_ready && n < 100) begin
      tick();
      n++;
    end
    checkOutput("second_accept_cycle", 80'(n), 80'(46));
    tick();
    gptp_ts_vaild = 1'b0;
    checkOutput("second_tx_start", 80'(tx_vaild), 80'(1));
    wait_drain();
    wait_ready();

    // Reset at byte 20
    $display("[TB] reset mid-frame");
    rtc_epoch_field = 16'd5;
    rtc_sec_field   = 32'd6;
    rtc_ns_base     = 32'd7;
    f = make_frame(8'h80, 8'h01);
    push_expect(f, mk_ts(16'd5, 32'd6, 32'd27));
    gptp_ts_data  = f;
    gptp_ts_vaild = 1'b1;
    wait_ready();
    tick();
    gptp_ts_vaild = 1'b0;
    repeat (20) tick();
    checkOutput("byte20_present", 80'(tx_data), 80'h94);
    reset = 1'b0;
    #1;
    checkOutput("midrst_ready", 80'(gptp_ts_ready), 80'(0));
    checkOutput("midrst_tx_vaild", 80'(tx_vaild), 80'(0));
    checkOutput("midrst_tx_last", 80'(tx_last), 80'(0));
    checkOutput("midrst_tx_data", 80'(tx_data), 80'(0));
    checkOutput("midrst_rv_vaild", 80'(gptp_ts_rv_vaild), 80'(0));
    checkOutput("midrst_rv_data", gptp_ts_rv_data, 80'(0));
    exp_q.delete();
    ts_q.delete();
    tick();
    tick();
    reset = 1'b1;
    checkOutput("midrst_release_pre", 80'(gptp_ts_ready), 80'(0));
    tick();
    checkOutput("midrst_release_post", 80'(gptp_ts_ready), 80'(1));
    repeat (5) tick();
    rtc_epoch_field = 16'd9;
    rtc_sec_field   = 32'd9;
    rtc_ns_base     = 32'd9;
    applyStimulus(make_frame(8'h60, 8'h01), mk_ts(16'd9, 32'd9, 32'd29));

    repeat (5) tick();
    checkOutput("queues_empty", 80'(exp_q.size() + ts_q.size()), 80'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
